// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter shared by instruction fetch (IF) and the MEM stage.
// MEM has priority; each access is grant -> busy (until MemReady or timeout) -> one-cycle response.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IFReq,
    input  logic [31:0] IFAddress,
    input  logic        MEMReadReq,
    input  logic        MEMWriteReq,
    input  logic [31:0] MEMAddress,
    input  logic [31:0] MEMWriteData,
    output logic [31:0] IFReadData,
    output logic        IFValid,
    output logic [31:0] MEMReadData,
    output logic        MEMValid,
    output logic        StallIF,
    output logic        StallMEM,
    output logic        MemEnable,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadDataIn,
    input  logic        MemReady,
    output logic        TimeoutError
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, RESP} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic        mem_valid_q, mem_valid_d;
    logic        timeout_q, timeout_d;
    logic        busy_done;
    logic [31:0] resp_data;

    // A timeout completes the access like MemReady would, but with zero data.
    assign busy_done = MemReady || (cnt_q == TIMEOUT_M1);
    assign resp_data = MemReady ? MemReadDataIn : 32'h0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                if (MEMReadReq || MEMWriteReq) begin
                    state_d = MEM_BUSY;
                    addr_d  = MEMAddress;
                    wdata_d = MEMWriteData;
                    wr_d    = MEMWriteReq;
                    cnt_d   = 8'd0;
                end else if (IFReq) begin
                    state_d = IF_BUSY;
                    addr_d  = IFAddress;
                    wr_d    = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (busy_done) begin
                    state_d = RESP;
                    if (!MemReady) timeout_d = 1'b1;
                    if (state_q == IF_BUSY) begin
                        if_rdata_d = resp_data;
                        if_valid_d = 1'b1;
                    end else begin
                        if (!wr_q) mem_rdata_d = resp_data;
                        mem_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wr_q        <= 1'b0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Memory-side strobes decode straight from state so an async reset drops them at once.
    assign MemEnable    = (state_q == IF_BUSY) || (state_q == MEM_BUSY);
    assign MemWrite     = (state_q == MEM_BUSY) && wr_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;

    assign IFReadData   = if_rdata_q;
    assign IFValid      = if_valid_q;
    assign MEMReadData  = mem_rdata_q;
    assign MEMValid     = mem_valid_q;
    assign TimeoutError = timeout_q;

    assign StallMEM = (MEMReadReq || MEMWriteReq) && !mem_valid_q;
    assign StallIF  = StallMEM || (IFReq && !if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle directed vectors for mem_port_arbiter (TIMEOUT=4), plus async-reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] rd_in = 32'h0;
    logic        rdy = 1'b0;
    logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
    logic        if_valid, mem_valid, stall_if, stall_mem, m_en, m_wr, t_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .Clk(clk), .Reset(rst_n),
        .IFReq(if_req), .IFAddress(if_addr),
        .MEMReadReq(mem_rd), .MEMWriteReq(mem_wr), .MEMAddress(mem_addr), .MEMWriteData(mem_wdata),
        .IFReadData(if_rdata), .IFValid(if_valid), .MEMReadData(mem_rdata), .MEMValid(mem_valid),
        .StallIF(stall_if), .StallMEM(stall_mem),
        .MemEnable(m_en), .MemWrite(m_wr), .MemAddress(m_addr), .MemWriteData(m_wdata),
        .MemReadDataIn(rd_in), .MemReady(rdy), .TimeoutError(t_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifq;
        logic [31:0] ifa;
        logic        mrd, mwr;
        logic [31:0] ma, mwd;
        logic        rdy;
        logic [31:0] rdin;
        logic        en, wr;
        logic [31:0] addr, wdata;
        logic        ifv;
        logic [31:0] ifd;
        logic        mv;
        logic [31:0] md;
        logic        sif, smem, terr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic ifq, input logic [31:0] ifa, input logic mrd, input logic mwr,
                               input logic [31:0] ma, input logic [31:0] mwd, input logic r, input logic [31:0] rdin,
                               input logic en, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ifv, input logic [31:0] ifd, input logic mv, input logic [31:0] md,
                               input logic sif, input logic smem, input logic terr);
        vec_t t;
        t.ifq = ifq; t.ifa = ifa; t.mrd = mrd; t.mwr = mwr; t.ma = ma; t.mwd = mwd; t.rdy = r; t.rdin = rdin;
        t.en = en; t.wr = wr; t.addr = addr; t.wdata = wdata; t.ifv = ifv; t.ifd = ifd; t.mv = mv; t.md = md;
        t.sif = sif; t.smem = smem; t.terr = terr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs | en wr addr wdata | IFValid IFReadData MEMValid MEMReadData | StallIF StallMEM TimeoutError
        // IF fetch 0x100 served in the first busy cycle
        vecs.push_back(v(1,32'h100,0,0,0,0,0,0,                 0,0,0,0, 0,32'h0,0,32'h0, 1,0,0));
        vecs.push_back(v(1,32'h100,0,0,0,0,1,32'h2402000A,      1,0,32'h100,0, 0,32'h0,0,32'h0, 1,0,0));
        vecs.push_back(v(1,32'h100,0,0,0,0,0,0,                 0,0,0,0, 1,32'h2402000A,0,32'h0, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,                       0,0,0,0, 0,32'h2402000A,0,32'h0, 0,0,0));
        // IF and MEM read together: MEM first, then IF
        vecs.push_back(v(1,32'h200,1,0,32'h40,0,0,0,            0,0,0,0, 0,32'h2402000A,0,32'h0, 1,1,0));
        vecs.push_back(v(1,32'h200,1,0,32'h40,0,1,32'h11112222, 1,0,32'h40,0, 0,32'h2402000A,0,32'h0, 1,1,0));
        vecs.push_back(v(1,32'h200,1,0,32'h40,0,0,0,            0,0,0,0, 0,32'h2402000A,1,32'h11112222, 1,0,0));
        vecs.push_back(v(1,32'h200,0,0,0,0,0,0,                 0,0,0,0, 0,32'h2402000A,0,32'h11112222, 1,0,0));
        vecs.push_back(v(1,32'h200,0,0,0,0,1,32'h33334444,      1,0,32'h200,0, 0,32'h2402000A,0,32'h11112222, 1,0,0));
        vecs.push_back(v(1,32'h200,0,0,0,0,0,0,                 0,0,0,0, 1,32'h33334444,0,32'h11112222, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,                       0,0,0,0, 0,32'h33334444,0,32'h11112222, 0,0,0));
        // Write 0x80; inputs change after grant; MemReady coincides with the timeout count
        vecs.push_back(v(0,0,0,1,32'h80,32'hDEADBEEF,0,0,       0,0,0,0, 0,32'h33334444,0,32'h11112222, 1,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0,0,0,1,32'hFFF0,0,0,0,            1,1,32'h80,32'hDEADBEEF, 0,32'h33334444,0,32'h11112222, 1,1,0));
        vecs.push_back(v(0,0,0,1,32'hFFF0,0,1,32'h55555555,     1,1,32'h80,32'hDEADBEEF, 0,32'h33334444,0,32'h11112222, 1,1,0));
        vecs.push_back(v(0,0,0,1,32'hFFF0,0,0,0,                0,0,0,0, 0,32'h33334444,1,32'h11112222, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,                       0,0,0,0, 0,32'h33334444,0,32'h11112222, 0,0,0));
        // Stray MemReady in IDLE/RESP; read+write together becomes a write
        vecs.push_back(v(0,0,0,0,0,0,1,32'h99999999,            0,0,0,0, 0,32'h33334444,0,32'h11112222, 0,0,0));
        vecs.push_back(v(0,0,1,1,32'hC0,32'hCAFEF00D,1,32'h99999999, 0,0,0,0, 0,32'h33334444,0,32'h11112222, 1,1,0));
        vecs.push_back(v(0,0,1,1,32'hC0,32'hCAFEF00D,1,32'h77777777, 1,1,32'hC0,32'hCAFEF00D, 0,32'h33334444,0,32'h11112222, 1,1,0));
        vecs.push_back(v(0,0,1,1,32'hC0,32'hCAFEF00D,1,32'h77777777, 0,0,0,0, 0,32'h33334444,1,32'h11112222, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,1,32'h77777777,            0,0,0,0, 0,32'h33334444,0,32'h11112222, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,0,0,                       0,0,0,0, 0,32'h33334444,0,32'h11112222, 0,0,0));
        // IF fetch with no MemReady: abort after 4 busy cycles, sticky error
        vecs.push_back(v(1,32'h300,0,0,0,0,0,0,                 0,0,0,0, 0,32'h33334444,0,32'h11112222, 1,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(1,32'h300,0,0,0,0,0,0,             1,0,32'h300,0, 0,32'h33334444,0,32'h11112222, 1,0,0));
        vecs.push_back(v(1,32'h300,0,0,0,0,0,0,                 0,0,0,0, 1,32'h0,0,32'h11112222, 0,0,1));
        vecs.push_back(v(0,0,0,0,0,0,0,0,                       0,0,0,0, 0,32'h0,0,32'h11112222, 0,0,1));
        vecs.push_back(v(0,0,0,0,0,0,1,32'h12345678,            0,0,0,0, 0,32'h0,0,32'h11112222, 0,0,1));

        // Held in reset with a request present: everything stays cleared
        if_req = 1'b1; if_addr = 32'h500;
        repeat (2) @(negedge clk);
        #1;
        chk("rst MemEnable", 32'(m_en), 32'h0);
        chk("rst MemWrite", 32'(m_wr), 32'h0);
        chk("rst MemAddress", m_addr, 32'h0);
        chk("rst MemWriteData", m_wdata, 32'h0);
        chk("rst IFValid", 32'(if_valid), 32'h0);
        chk("rst MEMValid", 32'(mem_valid), 32'h0);
        chk("rst IFReadData", if_rdata, 32'h0);
        chk("rst MEMReadData", mem_rdata, 32'h0);
        chk("rst TimeoutError", 32'(t_err), 32'h0);
        if_req = 1'b0; if_addr = 32'h0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            if_req = vecs[i].ifq; if_addr = vecs[i].ifa;
            mem_rd = vecs[i].mrd; mem_wr = vecs[i].mwr; mem_addr = vecs[i].ma; mem_wdata = vecs[i].mwd;
            rdy = vecs[i].rdy; rd_in = vecs[i].rdin;
            #1;
            chk($sformatf("v%0d MemEnable", i), 32'(m_en), 32'(vecs[i].en));
            chk($sformatf("v%0d MemWrite", i), 32'(m_wr), 32'(vecs[i].wr));
            if (vecs[i].en) chk($sformatf("v%0d MemAddress", i), m_addr, vecs[i].addr);
            if (vecs[i].wr) chk($sformatf("v%0d MemWriteData", i), m_wdata, vecs[i].wdata);
            chk($sformatf("v%0d IFValid", i), 32'(if_valid), 32'(vecs[i].ifv));
            chk($sformatf("v%0d IFReadData", i), if_rdata, vecs[i].ifd);
            chk($sformatf("v%0d MEMValid", i), 32'(mem_valid), 32'(vecs[i].mv));
            chk($sformatf("v%0d MEMReadData", i), mem_rdata, vecs[i].md);
            chk($sformatf("v%0d StallIF", i), 32'(stall_if), 32'(vecs[i].sif));
            chk($sformatf("v%0d StallMEM", i), 32'(stall_mem), 32'(vecs[i].smem));
            chk($sformatf("v%0d TimeoutError", i), 32'(t_err), 32'(vecs[i].terr));
        end

        // Async reset in the middle of a MEM read, then re-service of the held request
        @(negedge clk);
        if_req = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 32'h44; rdy = 1'b0; rd_in = 32'h0;
        @(negedge clk);
        #1;
        chk("arst busy MemEnable", 32'(m_en), 32'h1);
        chk("arst busy MemAddress", m_addr, 32'h44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst MemEnable drop", 32'(m_en), 32'h0);
        chk("arst MemAddress clear", m_addr, 32'h0);
        chk("arst TimeoutError clear", 32'(t_err), 32'h0);
        chk("arst MEMReadData clear", mem_rdata, 32'h0);
        chk("arst StallMEM", 32'(stall_mem), 32'h1);
        @(negedge clk);
        #1;
        chk("arst held MemEnable", 32'(m_en), 32'h0);
        chk("arst held MEMValid", 32'(mem_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("regrant MemEnable", 32'(m_en), 32'h1);
        chk("regrant MemWrite", 32'(m_wr), 32'h0);
        chk("regrant MemAddress", m_addr, 32'h44);
        chk("regrant MEMValid", 32'(mem_valid), 32'h0);
        rdy = 1'b1; rd_in = 32'hABCD0123;
        @(negedge clk);
        #1;
        chk("regrant resp MEMValid", 32'(mem_valid), 32'h1);
        chk("regrant resp MEMReadData", mem_rdata, 32'hABCD0123);
        chk("regrant resp StallMEM", 32'(stall_mem), 32'h0);
        chk("regrant resp TimeoutError", 32'(t_err), 32'h0);
        mem_rd = 1'b0; rdy = 1'b0; rd_in = 32'h0;
        @(negedge clk);
        #1;
        chk("after resp MEMValid", 32'(mem_valid), 32'h0);
        chk("after resp MemEnable", 32'(m_en), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for MemReady before abort (1..255).
REQ-002 SHALL have port Clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports IFReq in 1 (fetch request) and IFAddress in 32 (fetch word address).
REQ-005 SHALL have ports MEMReadReq in 1, MEMWriteReq in 1, MEMAddress in 32, MEMWriteData in 32 (MEM-stage load/store).
REQ-006 SHALL have outputs IFReadData 32, IFValid 1, MEMReadData 32, MEMValid 1 (registered responses).
REQ-007 SHALL have outputs StallIF 1 (hold PC and IF/ID) and StallMEM 1 (hold entire pipeline).
REQ-008 SHALL have memory-side outputs MemEnable 1, MemWrite 1, MemAddress 32, MemWriteData 32, and inputs MemReadDataIn 32, MemReady 1.
REQ-009 SHALL have output TimeoutError 1, sticky abort flag.

Function
REQ-010 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, RESP.
REQ-011 IDLE: SHALL sample requests only here; MEM request (read or write) has priority over IFReq; next state MEM_BUSY or IF_BUSY; none -> stay IDLE.
REQ-012 On grant, SHALL latch address, write data and write flag into internal registers; requester inputs ignored until RESP.
REQ-013 MEMReadReq and MEMWriteReq both high SHALL be serviced as a write.
REQ-014 In IF_BUSY/MEM_BUSY SHALL drive MemEnable=1, MemAddress/MemWriteData/MemWrite from latched registers; MemWrite=0 in IF_BUSY.
REQ-015 MemEnable SHALL be 0 in IDLE and RESP; MemWrite SHALL be 0 whenever MemEnable=0.
REQ-016 On MemReady=1 in a busy state SHALL capture MemReadDataIn into IFReadData (IF_BUSY) or MEMReadData (MEM read) and go to RESP.
REQ-017 MEM write completion SHALL leave MEMReadData unchanged.
REQ-018 RESP: SHALL assert exactly one of IFValid/MEMValid for exactly one cycle, per serviced requester; then IDLE unconditionally.
REQ-019 Minimum access = 3 cycles (grant, MemReady-in-first-busy-cycle, RESP); back-to-back accesses separated by one RESP cycle.
REQ-020 8-bit wait counter SHALL clear on grant, increment each busy cycle without MemReady.
REQ-021 If counter reaches TIMEOUT without MemReady, SHALL go to RESP, load response data 0, set TimeoutError=1.
REQ-022 MemReady and timeout in same cycle: MemReady wins, no error.
REQ-023 MemReady in IDLE or RESP SHALL be ignored.
REQ-024 TimeoutError SHALL stay set until Reset.
REQ-025 StallMEM SHALL be combinational: (MEMReadReq|MEMWriteReq) & ~MEMValid.
REQ-026 StallIF SHALL be combinational: StallMEM | (IFReq & ~IFValid).
REQ-027 IF request pending during MEM service SHALL be granted at next IDLE if still asserted (no starvation check needed; MEM stalls whole pipe).

Reset
REQ-028 Reset=0 SHALL immediately force state IDLE, counter 0, MemEnable=0, MemWrite=0, MemAddress=0, MemWriteData=0.
REQ-029 Reset=0 SHALL clear IFReadData=0, MEMReadData=0, IFValid=0, MEMValid=0, TimeoutError=0.
REQ-030 Reset mid-access SHALL abandon the access with no Valid pulse; after release the held request SHALL be re-granted from IDLE.

Verification
REQ-031 IFReq=1, IFAddress=0x100, MemReady on first busy cycle with data 0x2402000A -> MemEnable 1 cycle, IFValid pulse cycle 3 with IFReadData=0x2402000A, StallIF low that cycle.
REQ-032 IFReq and MEMReadReq both high in IDLE, addr 0x40 -> MEM granted first, StallIF/StallMEM high; MEMValid, then IF granted after RESP; IFValid follows.
REQ-033 MEMWriteReq=1, addr 0x80, data 0xDEADBEEF, MemReady after 4 cycles -> MemWrite=1 for 4 busy cycles, MEMValid pulse, MEMReadData unchanged.
REQ-034 TIMEOUT=4, MemReady never -> abort after 4 busy cycles, IFValid with IFReadData=0, TimeoutError=1 sticky.
REQ-035 Reset=0 asynchronously during MEM_BUSY -> MemEnable drops same instant, no MEMValid; after release request re-served normally.
REQ-036 MemReady pulse in IDLE and MEMReadReq+MEMWriteReq together -> stray ignored; access performed as write.
